jam_result_collector: RTL and testbench
=======================================

Name: jam_result_collector

Overview:
Downstream stage of the job-assignment machine (JAM). It snoops the 8x8 cost matrix streamed into the JAM and captures the JAM's 8-beat assignment burst. It recomputes the total cost from the stored matrix, checks that the assignment is a permutation and that the burst is well formed. It then presents one packed, flagged result word to the host through a valid/ready handshake.

Parameters:
N, 8, workers/jobs per problem; the matrix holds N*N entries.
CW, 7, width of one cost entry; matches in_cost.
JW, 4, width of one job index; matches out_job.
TW, 10, width of the total cost; matches out_cost (N*(2^CW-1)=1016 fits).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  JAM input stream valid (snooped).
in_cost  in  CW  JAM input cost, row-major: beat k = cost[worker k/N][job k%N].
jam_valid  in  1  JAM out_valid.
jam_job  in  JW  JAM out_job; beat i = job assigned to worker i.
jam_cost  in  TW  JAM out_cost.
res_valid  out  1  result word available.
res_ready  in  1  host accepts the result when res_valid && res_ready.
res_perm  out  N*JW  job of worker i in bits [i*JW +: JW].
res_cost  out  TW  jam_cost captured on the first burst beat.
res_sum  out  TW  recomputed sum of cost[i][job_i].
res_err  out  3  bit0 not a permutation; bit1 res_sum != res_cost or jam_cost changed mid-burst; bit2 burst length != N.
ovf  out  1  sticky; a new matrix arrived while a result was unaccepted.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state IDLE; res_valid=0; res_perm, res_cost, res_sum, res_err all 0; ovf=0; busy=0; load and beat counters 0. Matrix contents are don't-care.
- FSM states and transitions:
  - IDLE: on in_valid, store the beat at index 0 and go to LOAD (count=1).
  - LOAD: each in_valid beat stores at index count and increments count. Gaps (in_valid=0) are allowed. After beat N*N-1 is stored, go to WAIT. jam_valid is ignored in IDLE and LOAD.
  - WAIT: go to COLLECT on the first jam_valid beat, processing that beat.
  - COLLECT: each jam_valid beat with index i<N:
    - writes jam_job into res_perm field i;
    - sets used-mask bit jam_job; if jam_job>=N or the bit is already set, res_err[0]=1 and the beat adds 0 to res_sum;
    - otherwise adds cost[i][jam_job] to res_sum.
  - COLLECT, other cases:
    - Beat 0 latches jam_cost into res_cost.
    - A later beat whose jam_cost differs from res_cost sets res_err[1].
    - Beats with i>=N set res_err[2] and are otherwise ignored.
  - COLLECT end: on the first cycle with jam_valid=0, go to HOLD with res_valid=1.
    - Fewer than N beats sets res_err[2]; missing perm fields stay 0.
    - res_err[1] is also set if res_sum != res_cost.
  - HOLD: hold every res_* output stable while res_valid && !res_ready. On handshake, the next cycle has res_valid=0, state IDLE, and perm/sum/err/mask cleared. res_cost is cleared at the next burst's beat 0.
- Latency: res_valid rises 2 cycles after the cycle holding the last jam_valid beat. res_ready may already be high; the handshake then completes in the first HOLD cycle.
- in_valid in WAIT, COLLECT or HOLD: the beat is dropped and ovf=1, sticky until rst.
- jam_valid in HOLD is ignored.
- Sum: unsigned, TW bits, no saturation needed.
- Reset mid-load, mid-burst or in HOLD: abandon everything and return to the reset state on the next edge. No partial result is emitted.

Test Plan:
- Matrix cost[i][j]=(i==j)?1:10. JAM burst jobs 0..7, jam_cost=8 -> res_perm=0x76543210, res_sum=8, res_cost=8, res_err=0; res_valid 2 cycles after beat 7.
- Same matrix, jobs 1,0,2..7, jam_cost=8 -> res_sum=26, res_err=3'b010.
- Jobs 0,0,2..7 -> res_err[0]=1. Jobs 9,1..7 -> res_err[0]=1. In both, res_sum excludes the offending beat.
- 7-beat burst -> res_err[2]=1, res_perm[31:28]=0. 9-beat burst -> res_err[2]=1, perm equals the first 8 beats.
- res_ready low for 5 cycles with in_valid pulsed during HOLD -> outputs stable for 5 cycles, ovf=1, then handshake returns to IDLE (busy=0).
- rst pulsed at load beat 30 -> all outputs 0 next cycle. A full 64-beat reload plus a good burst then yields a correct result.

Source files
------------

// File: rtl/jam_result_collector.sv
// Snoops the JAM 8x8 cost matrix, captures the assignment burst and emits one checked result word.
// res_valid rises 2 cycles after the last burst beat and the result is held stable until res_ready.
module jam_result_collector #(
  parameter int N  = 8,
  parameter int CW = 7,
  parameter int JW = 4,
  parameter int TW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [CW-1:0]   in_cost,
  input  logic            jam_valid,
  input  logic [JW-1:0]   jam_job,
  input  logic [TW-1:0]   jam_cost,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N*JW-1:0] res_perm,
  output logic [TW-1:0]   res_cost,
  output logic [TW-1:0]   res_sum,
  output logic [2:0]      res_err,
  output logic            ovf,
  output logic            busy
);
  localparam int CLW = (N > 1) ? $clog2(N) : 1;
  localparam int BW  = $clog2(N + 1);
  localparam int UW  = 1 << CLW;
  localparam logic [CLW-1:0] LAST_IDX = CLW'(N - 1);
  localparam logic [JW-1:0]  JOB_LIM  = JW'(N);
  localparam logic [BW-1:0]  BEAT_LIM = BW'(N);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_COLLECT, S_HOLD} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_mat [N][N];
  logic [CLW-1:0]  r_ld_row;
  logic [CLW-1:0]  r_ld_col;
  logic [BW-1:0]   r_bt_cnt;
  logic [UW-1:0]   r_used;
  logic [N*JW-1:0] r_perm;
  logic [TW-1:0]   r_cost;
  logic [TW-1:0]   r_sum;
  logic [2:0]      r_err;
  logic            r_valid;
  logic            r_ovf;

  logic            w_ld_we;
  logic            w_ld_last;
  logic            w_beat;
  logic            w_idx_ok;
  logic            w_job_ok;
  logic            w_bad;
  logic [CLW-1:0]  w_row;
  logic [CLW-1:0]  w_job_lo;
  logic [TW-1:0]   w_add;

  assign w_ld_we   = in_valid && (r_state == S_IDLE || r_state == S_LOAD);
  assign w_ld_last = (r_ld_row == LAST_IDX) && (r_ld_col == LAST_IDX);
  assign w_beat    = jam_valid && (r_state == S_WAIT || r_state == S_COLLECT);
  assign w_idx_ok  = r_bt_cnt < BEAT_LIM;
  assign w_job_ok  = jam_job < JOB_LIM;
  assign w_row     = r_bt_cnt[CLW-1:0];
  assign w_job_lo  = jam_job[CLW-1:0];
  // An out-of-range or repeated job contributes nothing to the recomputed sum.
  assign w_bad     = !w_job_ok || r_used[w_job_lo];
  assign w_add     = w_bad ? '0 : TW'(r_mat[w_row][w_job_lo]);

  always_ff @(posedge clk) begin
    if (w_ld_we) begin
      r_mat[r_ld_row][r_ld_col] <= in_cost;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ld_row <= '0;
      r_ld_col <= '0;
      r_bt_cnt <= '0;
      r_used   <= '0;
      r_perm   <= '0;
      r_cost   <= '0;
      r_sum    <= '0;
      r_err    <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (in_valid && (r_state == S_WAIT || r_state == S_COLLECT || r_state == S_HOLD)) begin
        r_ovf <= 1'b1;
      end

      if (w_ld_we) begin
        if (r_ld_col == LAST_IDX) begin
          r_ld_col <= '0;
          r_ld_row <= w_ld_last ? '0 : r_ld_row + CLW'(1);
        end else begin
          r_ld_col <= r_ld_col + CLW'(1);
        end
      end

      // Beat counter stops at N; surplus beats only flag a length error.
      if (w_beat) begin
        if (w_idx_ok) begin
          r_perm[w_row*JW +: JW] <= jam_job;
          if (w_job_ok) begin
            r_used[w_job_lo] <= 1'b1;
          end
          if (w_bad) begin
            r_err[0] <= 1'b1;
          end
          r_sum <= r_sum + w_add;
          if (r_bt_cnt == '0) begin
            r_cost <= jam_cost;
          end else if (jam_cost != r_cost) begin
            r_err[1] <= 1'b1;
          end
          r_bt_cnt <= r_bt_cnt + BW'(1);
        end else begin
          r_err[2] <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid && w_ld_last) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (jam_valid) begin
            r_state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (!jam_valid) begin
            r_state <= S_HOLD;
            r_valid <= 1'b1;
            if (w_idx_ok) begin
              r_err[2] <= 1'b1;
            end
            if (r_sum != r_cost) begin
              r_err[1] <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // res_cost survives the handshake and is replaced by the next burst's first beat.
          if (res_ready) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_perm   <= '0;
            r_sum    <= '0;
            r_err    <= '0;
            r_used   <= '0;
            r_bt_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign res_valid = r_valid;
  assign res_perm  = r_perm;
  assign res_cost  = r_cost;
  assign res_sum   = r_sum;
  assign res_err   = r_err;
  assign ovf       = r_ovf;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_jam_result_collector.sv
// Bench for jam_result_collector: directed scenarios plus randomized matrices and bursts,
// checked each cycle against a burst-level reference model.
module tb_jam_result_collector;
  localparam int N  = 8;
  localparam int CW = 7;
  localparam int JW = 4;
  localparam int TW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [CW-1:0]   in_cost;
  logic            jam_valid;
  logic [JW-1:0]   jam_job;
  logic [TW-1:0]   jam_cost;
  logic            res_valid;
  logic            res_ready;
  logic [N*JW-1:0] res_perm;
  logic [TW-1:0]   res_cost;
  logic [TW-1:0]   res_sum;
  logic [2:0]      res_err;
  logic            ovf;
  logic            busy;

  jam_result_collector #(.N(N), .CW(CW), .JW(JW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cost(in_cost),
    .jam_valid(jam_valid), .jam_job(jam_job), .jam_cost(jam_cost),
    .res_valid(res_valid), .res_ready(res_ready), .res_perm(res_perm),
    .res_cost(res_cost), .res_sum(res_sum), .res_err(res_err),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mat [N][N];
  int bj [16];
  int bc [16];
  int blen;

  logic            cmp_en = 1'b0;
  logic            exp_valid = 1'b0;
  logic            exp_ovf = 1'b0;
  logic [N*JW-1:0] exp_perm;
  logic [TW-1:0]   exp_cost;
  logic [TW-1:0]   exp_sum;
  logic [2:0]      exp_err;

  logic            lit_en = 1'b0;
  logic [N*JW-1:0] lit_perm;
  logic [TW-1:0]   lit_cost;
  logic [TW-1:0]   lit_sum;
  logic [2:0]      lit_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("res_valid", 64'(res_valid), 64'(exp_valid));
      chk("ovf", 64'(ovf), 64'(exp_ovf));
      if (exp_valid) begin
        chk("res_perm", 64'(res_perm), 64'(exp_perm));
        chk("res_cost", 64'(res_cost), 64'(exp_cost));
        chk("res_sum", 64'(res_sum), 64'(exp_sum));
        chk("res_err", 64'(res_err), 64'(exp_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: diagonal 1 / off-diagonal 10; mode 1: random costs.
  task automatic load_matrix(input int mode, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      int v;
      while ($urandom_range(0, 3) == 0) begin
        in_valid  = 1'b0;
        jam_valid = ($urandom_range(0, 1) == 1);
        jam_job   = JW'($urandom_range(0, 15));
        tick();
      end
      v = (mode == 0) ? (((k / N) == (k % N)) ? 1 : 10) : int'($urandom_range(0, 127));
      mat[k / N][k % N] = v;
      in_valid  = 1'b1;
      in_cost   = CW'(v);
      jam_valid = ($urandom_range(0, 1) == 1);
      jam_job   = JW'($urandom_range(0, 15));
      tick();
      if (k == 0) chk("busy_load", 64'(busy), 64'd1);
    end
    in_valid  = 1'b0;
    jam_valid = 1'b0;
    jam_job   = '0;
  endtask

  // Burst-level reference: what the result word must hold after the burst in bj/bc.
  task automatic model();
    logic [N-1:0]    used = '0;
    int              s = 0;
    int              c = bc[0];
    logic [2:0]      e = '0;
    logic [N*JW-1:0] p = '0;
    for (int b = 0; b < blen; b++) begin
      if (b < N) begin
        p[b*JW +: JW] = bj[b][JW-1:0];
        if (bj[b] >= N || used[bj[b]]) e[0] = 1'b1;
        else begin
          s = s + mat[b][bj[b]];
          used[bj[b]] = 1'b1;
        end
        if (b > 0 && bc[b] != c) e[1] = 1'b1;
      end else begin
        e[2] = 1'b1;
      end
    end
    if (blen < N) e[2] = 1'b1;
    s = s % (1 << TW);
    if (s != c) e[1] = 1'b1;
    exp_perm = p;
    exp_cost = TW'(c);
    exp_sum  = TW'(s);
    exp_err  = e;
  endtask

  task automatic run_burst(input int delay, input bit pulse);
    model();
    res_ready = (delay == 0);
    for (int b = 0; b < blen; b++) begin
      jam_valid = 1'b1;
      jam_job   = JW'(bj[b]);
      jam_cost  = TW'(bc[b]);
      tick();
    end
    jam_valid = 1'b0;
    jam_job   = '0;
    jam_cost  = '0;
    tick();
    exp_valid = 1'b1;
    if (lit_en) begin
      chk("lit_perm", 64'(res_perm), 64'(lit_perm));
      chk("lit_cost", 64'(res_cost), 64'(lit_cost));
      chk("lit_sum", 64'(res_sum), 64'(lit_sum));
      chk("lit_err", 64'(res_err), 64'(lit_err));
    end
    if (delay == 0) begin
      tick();
    end else begin
      for (int d = 0; d < delay; d++) begin
        in_valid = pulse && (d == 1);
        tick();
        if (in_valid) exp_ovf = 1'b1;
        in_valid = 1'b0;
      end
      res_ready = 1'b1;
      tick();
    end
    exp_valid = 1'b0;
    res_ready = 1'b0;
    lit_en    = 1'b0;
    chk("busy_after_hs", 64'(busy), 64'd0);
    chk("perm_cleared", 64'(res_perm), 64'd0);
    chk("sum_cleared", 64'(res_sum), 64'd0);
    chk("err_cleared", 64'(res_err), 64'd0);
    chk("cost_retained", 64'(res_cost), 64'(exp_cost));
  endtask

  task automatic set_ident(input int len, input int jc);
    blen = len;
    for (int b = 0; b < 16; b++) begin
      bj[b] = b % N;
      bc[b] = jc;
    end
  endtask

  task automatic set_lit(input logic [N*JW-1:0] p, input int c, input int s, input logic [2:0] e);
    lit_en   = 1'b1;
    lit_perm = p;
    lit_cost = TW'(c);
    lit_sum  = TW'(s);
    lit_err  = e;
  endtask

  task automatic rand_test();
    int r;
    int delay;
    r = $urandom_range(0, 9);
    blen = (r == 0) ? 7 : (r == 1) ? 9 : (r == 2) ? 5 : 8;
    for (int i = 0; i < 16; i++) bj[i] = (i < N) ? i : int'($urandom_range(0, 15));
    for (int i = N - 1; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = bj[i];
      bj[i] = bj[j];
      bj[j] = t;
    end
    if ($urandom_range(0, 3) == 0) bj[$urandom_range(0, N - 1)] = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++) bc[i] = $urandom_range(0, 1023);
    if ($urandom_range(0, 1) == 0) begin
      model();
      for (int i = 0; i < 16; i++) bc[i] = int'(exp_sum);
    end else begin
      for (int i = 1; i < 16; i++) bc[i] = bc[0];
    end
    if (blen > 1 && $urandom_range(0, 5) == 0) begin
      r = $urandom_range(1, blen - 1);
      bc[r] = (bc[r] + 1) % 1024;
    end
    load_matrix(1, N * N);
    delay = $urandom_range(0, 3);
    run_burst(delay, (delay >= 2) && ($urandom_range(0, 1) == 1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_cost = '0; jam_valid = 1'b0;
    jam_job = '0; jam_cost = '0; res_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_perm", 64'(res_perm), 64'd0);
    chk("rst_cost", 64'(res_cost), 64'd0);
    chk("rst_sum", 64'(res_sum), 64'd0);
    chk("rst_err", 64'(res_err), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    load_matrix(0, N * N); set_ident(8, 8);
    set_lit(32'h76543210, 8, 8, 3'b000); run_burst(0, 1'b0);

    load_matrix(0, N * N); set_ident(8, 8); bj[0] = 1; bj[1] = 0;
    set_lit(32'h76543201, 8, 26, 3'b010); run_burst(1, 1'b0);

    load_matrix(0, N * N); set_ident(8, 8); bj[1] = 0;
    set_lit(32'h76543200, 8, 7, 3'b011); run_burst(0, 1'b0);

    load_matrix(0, N * N); set_ident(8, 8); bj[0] = 9;
    set_lit(32'h76543219, 8, 7, 3'b011); run_burst(2, 1'b0);

    load_matrix(0, N * N); set_ident(7, 7);
    set_lit(32'h06543210, 7, 7, 3'b100); run_burst(0, 1'b0);

    load_matrix(0, N * N); set_ident(9, 8);
    set_lit(32'h76543210, 8, 8, 3'b100); run_burst(0, 1'b0);

    load_matrix(0, N * N); set_ident(8, 8);
    set_lit(32'h76543210, 8, 8, 3'b000); run_burst(5, 1'b1);
    chk("ovf_sticky", 64'(ovf), 64'd1);

    load_matrix(0, 30);
    rst = 1'b1; in_valid = 1'b1; in_cost = 7'd5;
    tick();
    exp_ovf = 1'b0; exp_valid = 1'b0;
    in_valid = 1'b0;
    chk("midrst_valid", 64'(res_valid), 64'd0);
    chk("midrst_perm", 64'(res_perm), 64'd0);
    chk("midrst_cost", 64'(res_cost), 64'd0);
    chk("midrst_sum", 64'(res_sum), 64'd0);
    chk("midrst_err", 64'(res_err), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    load_matrix(0, N * N); set_ident(8, 8);
    set_lit(32'h76543210, 8, 8, 3'b000); run_burst(0, 1'b0);

    for (int t = 0; t < 20; t++) rand_test();

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
